// File: rtl/hpi_access_sequencer_pkg.sv
// Shared types and constants for the CY7C67300 HPI access sequencer.
package hpi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } hpi_state_e;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDR    = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hpi_access_sequencer_if.sv
// Requester-side handshake bundle: two request channels plus shared read data and busy.
interface hpi_access_sequencer_if;
  logic        req0_valid;
  logic        req0_write;
  logic [1:0]  req0_addr;
  logic [15:0] req0_wdata;
  logic        req0_ack;
  logic        req1_valid;
  logic        req1_write;
  logic [1:0]  req1_addr;
  logic [15:0] req1_wdata;
  logic        req1_ack;
  logic [15:0] rdata;
  logic        busy;

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req0_ack, req1_ack, rdata, busy
  );

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req0_ack, req1_ack, rdata, busy
  );
endinterface

// File: rtl/hpi_access_sequencer_irq_sync.sv
// Two-flop synchroniser for the HPI interrupt, rising-edge detect and sticky pending flag.
module hpi_irq_sync (
  input  logic sys_clk,
  input  logic usbreset,
  input  logic irq_async_i,
  input  logic irq_clear_i,
  output logic irq_pending_o
);
  logic sync1_q, sync2_q, prev_q, pending_q;
  logic rise_s, pending_d;

  // Set has priority so an edge arriving with a clear is never lost.
  always_comb begin
    rise_s    = sync2_q & ~prev_q;
    pending_d = pending_q;
    if (rise_s) begin
      pending_d = 1'b1;
    end else if (irq_clear_i) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Synchroniser, edge history and pending flag.
  always_ff @(posedge sys_clk or posedge usbreset) begin
    if (usbreset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync1_q   <= irq_async_i;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      pending_q <= pending_d;
    end
  end

  assign irq_pending_o = pending_q;
endmodule

// File: rtl/hpi_access_sequencer.sv
// Round-robin arbitrated HPI cycle sequencer; every output is driven straight from a flop.
module hpi_access_sequencer
  import hpi_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 6,
  parameter int HOLD_CYC   = 2
) (
  input  logic                         sys_clk,
  input  logic                         usbreset,
  hpi_access_sequencer_if.slave        req_if,
  output logic [1:0]                   cy_hpi_address,
  output logic [15:0]                  cy_hpi_data_o,
  output logic                         cy_hpi_data_oe,
  input  logic [15:0]                  cy_hpi_data_i,
  output logic                         cy_hpi_csn,
  output logic                         cy_hpi_oen,
  output logic                         cy_hpi_wen,
  input  logic                         cy_hpi_irq,
  output logic                         irq_pending,
  input  logic                         irq_clear
);
  localparam int CW = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);

  if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_timing
    $error("hpi_access_sequencer: SETUP_CYC, STROBE_CYC and HOLD_CYC must all be >= 1");
  end

  hpi_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        rr_q, rr_d, gnt_q, gnt_d, wr_q, wr_d, sel_s;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] data_o_q, data_o_d, rdata_q, rdata_d;
  logic        data_oe_q, data_oe_d, csn_q, csn_d, oen_q, oen_d, wen_q, wen_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d, busy_q, busy_d;

  // Arbitration, phase sequencing and next values of all registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    data_o_d = data_o_q;
    rdata_d  = rdata_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    sel_s    = rr_q ? req_if.req1_valid : ~req_if.req0_valid;
    case (state_q)
      ST_IDLE: begin
        // The ack cycle never grants, guaranteeing a csn-high gap between transactions.
        if ((req_if.req0_valid || req_if.req1_valid) && !ack0_q && !ack1_q) begin
          gnt_d   = sel_s;
          rr_d    = ~sel_s;
          wr_d    = sel_s ? req_if.req1_write : req_if.req0_write;
          addr_d  = sel_s ? req_if.req1_addr  : req_if.req0_addr;
          if (wr_d) begin
            data_o_d = sel_s ? req_if.req1_wdata : req_if.req0_wdata;
          end else begin
            data_o_d = data_o_q;
          end
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
          if (!wr_q) begin
            rdata_d = cy_hpi_data_i;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (gnt_q) begin
            ack1_d = 1'b1;
          end else begin
            ack0_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    csn_d     = (state_d == ST_IDLE);
    oen_d     = !((state_d == ST_STROBE) && !wr_d);
    wen_d     = !((state_d == ST_STROBE) && wr_d);
    data_oe_d = (state_d != ST_IDLE) && wr_d;
    busy_d    = (state_d != ST_IDLE) || ack0_d || ack1_d;
  end

  // State and output registers.
  always_ff @(posedge sys_clk or posedge usbreset) begin
    if (usbreset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rr_q      <= 1'b0;
      gnt_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= 2'd0;
      data_o_q  <= 16'h0000;
      rdata_q   <= 16'h0000;
      data_oe_q <= 1'b0;
      csn_q     <= 1'b1;
      oen_q     <= 1'b1;
      wen_q     <= 1'b1;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_o_q  <= data_o_d;
      rdata_q   <= rdata_d;
      data_oe_q <= data_oe_d;
      csn_q     <= csn_d;
      oen_q     <= oen_d;
      wen_q     <= wen_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      busy_q    <= busy_d;
    end
  end

  hpi_irq_sync u_irq_sync (
    .sys_clk       (sys_clk),
    .usbreset      (usbreset),
    .irq_async_i   (cy_hpi_irq),
    .irq_clear_i   (irq_clear),
    .irq_pending_o (irq_pending)
  );

  assign cy_hpi_address = addr_q;
  assign cy_hpi_data_o  = data_o_q;
  assign cy_hpi_data_oe = data_oe_q;
  assign cy_hpi_csn     = csn_q;
  assign cy_hpi_oen     = oen_q;
  assign cy_hpi_wen     = wen_q;
  assign req_if.rdata    = rdata_q;
  assign req_if.req0_ack = ack0_q;
  assign req_if.req1_ack = ack1_q;
  assign req_if.busy     = busy_q;
endmodule

// File: tb/tb_hpi_access_sequencer.sv
// Directed bench for hpi_access_sequencer: timing masks, arbitration order, reset abort and IRQ capture.
module tb_hpi_access_sequencer;
  import hpi_pkg::*;

  logic        sys_clk = 1'b0;
  logic        usbreset;
  logic [1:0]  cy_hpi_address;
  logic [15:0] cy_hpi_data_o;
  logic        cy_hpi_data_oe;
  logic [15:0] cy_hpi_data_i;
  logic        cy_hpi_csn, cy_hpi_oen, cy_hpi_wen;
  logic        cy_hpi_irq, irq_pending, irq_clear;

  hpi_access_sequencer_if req_if ();

  hpi_access_sequencer dut (
    .sys_clk        (sys_clk),
    .usbreset       (usbreset),
    .req_if         (req_if),
    .cy_hpi_address (cy_hpi_address),
    .cy_hpi_data_o  (cy_hpi_data_o),
    .cy_hpi_data_oe (cy_hpi_data_oe),
    .cy_hpi_data_i  (cy_hpi_data_i),
    .cy_hpi_csn     (cy_hpi_csn),
    .cy_hpi_oen     (cy_hpi_oen),
    .cy_hpi_wen     (cy_hpi_wen),
    .cy_hpi_irq     (cy_hpi_irq),
    .irq_pending    (irq_pending),
    .irq_clear      (irq_clear)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] csn_m, oen_m, wen_m, oe_m, ack0_m, ack1_m;
  int          data_err;
  logic [15:0] rd_at_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_req(input bit n, input logic v, input logic wr, input logic [1:0] a,
                         input logic [15:0] wd);
    if (n) begin
      req_if.req1_valid = v; req_if.req1_write = wr; req_if.req1_addr = a; req_if.req1_wdata = wd;
    end else begin
      req_if.req0_valid = v; req_if.req0_write = wr; req_if.req0_addr = a; req_if.req0_wdata = wd;
    end
  endtask

  // Issue one request and record per-cycle activity as bit masks (bit i = i-th cycle after request).
  task automatic run_txn(input bit n, input logic wr, input logic [1:0] a, input logic [15:0] wd);
    csn_m = 32'd0; oen_m = 32'd0; wen_m = 32'd0; oe_m = 32'd0; ack0_m = 32'd0; ack1_m = 32'd0;
    data_err = 0;
    rd_at_ack = 16'hXXXX;
    set_req(n, 1'b1, wr, a, wd);
    for (int i = 1; i <= 20; i++) begin
      step();
      csn_m[i]  = ~cy_hpi_csn;
      oen_m[i]  = ~cy_hpi_oen;
      wen_m[i]  = ~cy_hpi_wen;
      oe_m[i]   = cy_hpi_data_oe;
      ack0_m[i] = req_if.req0_ack;
      ack1_m[i] = req_if.req1_ack;
      if (!cy_hpi_csn && ((cy_hpi_address !== a) || (wr && (cy_hpi_data_o !== wd)))) data_err++;
      if (req_if.req0_ack || req_if.req1_ack) begin
        rd_at_ack = req_if.rdata;
        set_req(n, 1'b0, wr, a, wd);
      end
    end
  endtask

  int          dev, k, hi_run, min_gap;
  bit          seen_low;
  logic [3:0]  order;
  int          t_ack [4];

  initial begin
    usbreset = 1'b1;
    cy_hpi_data_i = 16'h1234;
    cy_hpi_irq = 1'b0;
    irq_clear = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
    set_req(1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);

    // 1: reset values, then 100 quiet cycles
    #3;
    chk("rst_strobes", {29'd0, cy_hpi_csn, cy_hpi_oen, cy_hpi_wen}, 32'd7);
    chk("rst_data_oe", {31'd0, cy_hpi_data_oe}, 32'd0);
    chk("rst_acks", {30'd0, req_if.req0_ack, req_if.req1_ack}, 32'd0);
    chk("rst_busy_irq", {30'd0, req_if.busy, irq_pending}, 32'd0);
    chk("rst_addr_data", {14'd0, cy_hpi_address, cy_hpi_data_o}, 32'd0);
    chk("rst_rdata", {16'd0, req_if.rdata}, 32'd0);
    step(); step();
    usbreset = 1'b0;
    dev = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if ({cy_hpi_csn, cy_hpi_oen, cy_hpi_wen} !== 3'b111 || cy_hpi_data_oe !== 1'b0 ||
          req_if.req0_ack !== 1'b0 || req_if.req1_ack !== 1'b0 || req_if.busy !== 1'b0) dev++;
    end
    chk("idle_quiet", dev, 32'd0);

    // 2: req0 write to mailbox
    run_txn(1'b0, 1'b1, HPI_MAILBOX, 16'h00AA);
    chk("wr_csn_mask", csn_m, 32'h0000_07FE);
    chk("wr_wen_mask", wen_m, 32'h0000_01F8);
    chk("wr_oen_mask", oen_m, 32'h0000_0000);
    chk("wr_oe_mask", oe_m, 32'h0000_07FE);
    chk("wr_ack0", ack0_m, 32'h0000_0800);
    chk("wr_ack1", ack1_m, 32'h0000_0000);
    chk("wr_addr_data", data_err, 32'd0);

    // 3: req1 read from data register
    cy_hpi_data_i = 16'h03DD;
    run_txn(1'b1, 1'b0, HPI_DATA, 16'h0000);
    chk("rd_csn_mask", csn_m, 32'h0000_07FE);
    chk("rd_oen_mask", oen_m, 32'h0000_01F8);
    chk("rd_wen_mask", wen_m, 32'h0000_0000);
    chk("rd_oe_mask", oe_m, 32'h0000_0000);
    chk("rd_ack1", ack1_m, 32'h0000_0800);
    chk("rd_ack0", ack0_m, 32'h0000_0000);
    chk("rd_data", {16'd0, rd_at_ack}, 32'h0000_03DD);
    chk("rd_addr", data_err, 32'd0);

    // 4: both requesters held valid -> alternating grants, 12-cycle period
    set_req(1'b0, 1'b1, 1'b0, HPI_STATUS, 16'h0000);
    set_req(1'b1, 1'b1, 1'b0, HPI_ADDR, 16'h0000);
    k = 0; hi_run = 0; min_gap = 99; seen_low = 1'b0; order = 4'b0000;
    for (int i = 1; i <= 80 && k < 4; i++) begin
      step();
      if (!cy_hpi_csn) begin
        if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
        hi_run = 0;
        seen_low = 1'b1;
      end else if (seen_low) begin
        hi_run++;
      end
      if (req_if.req0_ack || req_if.req1_ack) begin
        order[3-k] = req_if.req1_ack;
        t_ack[k] = i;
        k++;
        if (k == 4) begin
          set_req(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
          set_req(1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
        end
      end
    end
    chk("rr_ack_count", k, 32'd4);
    chk("rr_order", {28'd0, order}, 32'b0101);
    chk("rr_period_a", t_ack[1] - t_ack[0], 32'd12);
    chk("rr_period_b", t_ack[3] - t_ack[2], 32'd12);
    chk("rr_csn_gap", {31'd0, min_gap >= 1 && min_gap < 99}, 32'd1);
    step(); step();

    // 5: reset during STROBE aborts the read without an ack
    set_req(1'b0, 1'b1, 1'b0, HPI_MAILBOX, 16'h0000);
    for (int i = 0; i < 5; i++) step();
    chk("abort_in_strobe", {31'd0, cy_hpi_oen}, 32'd0);
    usbreset = 1'b1;
    #1;
    chk("abort_strobes", {29'd0, cy_hpi_csn, cy_hpi_oen, cy_hpi_wen}, 32'd7);
    chk("abort_busy_oe", {30'd0, req_if.busy, cy_hpi_data_oe}, 32'd0);
    chk("abort_rdata", {16'd0, req_if.rdata}, 32'd0);
    set_req(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
    dev = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (req_if.req0_ack || req_if.req1_ack) dev++;
    end
    usbreset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (req_if.req0_ack || req_if.req1_ack) dev++;
    end
    chk("abort_no_ack", dev, 32'd0);
    run_txn(1'b1, 1'b1, HPI_ADDR, 16'hBEEF);
    chk("post_rst_csn", csn_m, 32'h0000_07FE);
    chk("post_rst_wen", wen_m, 32'h0000_01F8);
    chk("post_rst_ack1", ack1_m, 32'h0000_0800);
    chk("post_rst_data", data_err, 32'd0);

    // 6: 20 ns irq pulse, sticky flag, clear, and set-beats-clear
    cy_hpi_irq = 1'b1;
    step();
    step();
    cy_hpi_irq = 1'b0;
    step();
    chk("irq_set_3cyc", {31'd0, irq_pending}, 32'd1);
    step(); step();
    chk("irq_sticky", {31'd0, irq_pending}, 32'd1);
    irq_clear = 1'b1;
    step();
    irq_clear = 1'b0;
    chk("irq_cleared", {31'd0, irq_pending}, 32'd0);
    step();
    cy_hpi_irq = 1'b1;
    step();
    step();
    irq_clear = 1'b1;
    step();
    irq_clear = 1'b0;
    chk("irq_set_beats_clear", {31'd0, irq_pending}, 32'd1);
    step();
    chk("irq_still_set", {31'd0, irq_pending}, 32'd1);
    cy_hpi_irq = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
